hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised pipeline hazard and forwarding controller for the 16-bit core. It replaces per-instruction forwarding compares with a DEPTH-stage destination scoreboard. It adds load-use stall, branch flush, a latched flag register, and an EXEC sequencing FSM. It sits beside the decode stage, consumes the decoded instruction fields, and drives operand-mux selects and pipeline stall/flush.

Parameters:
RSIZE, 4, register address width
DEPTH, 2, number of in-flight stages tracked for forwarding (1..4)
SELW, 3, forwarding select width; must satisfy 2**SELW > DEPTH

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_valid  in  1  decode slot holds a real instruction
id_opcode  in  4  decoded opcode
id_cond  in  3  branch condition field
id_rd  in  RSIZE  destination register
id_rs  in  RSIZE  source 1
id_rt  in  RSIZE  source 2
alu_flag  in  3  {N,V,Z} from execute
alu_flag_we  in  1  execute instruction updates flags (ADD/SUB/AND/OR)
fwd_sel_rs  out  SELW  0 = register file; k = result of scoreboard stage k-1
fwd_sel_rt  out  SELW  same, for second operand
stall  out  1  hold fetch/decode and insert bubble
flush  out  1  kill the instruction in fetch
branch_taken  out  1  redirect PC to branch/jump target
exec_active  out  1  EXEC target instruction occupies decode

Behaviour:
- Single clock, synchronous active-high reset. On reset: scoreboard entries invalid, flag reg = 3'b000, FSM = IDLE, flush = 0, exec_active = 0. Combinational outputs then evaluate to 0.
- Reg-writing opcodes: 0x0–0x8, 0xA, 0xB, 0xD. For JAL (0xD) the destination is id_rd. Loads: opcode 0x8.
- Sources used:
  - rs for opcodes 0x0–0x9.
  - rt for 0x0–0x3.
  - rd as a read operand for SW (0x9), JR (0xE) and EXEC (0xF).
  - The rd read operand maps onto fwd_sel_rt.
- Scoreboard:
  - DEPTH entries {valid, rd, is_load}; stage 0 is the youngest.
  - Each clk without stall: shift by one. Stage 0 loads {id_valid & writes, id_rd, is_load}.
  - On stall: stage 0 loads a bubble (valid = 0) and the older stages still shift.
- Forwarding (combinational):
  - The youngest valid stage whose rd equals the source and rd != 0 wins. sel = index + 1.
  - No match, or source == 0, gives sel = 0.
- Load-use stall (combinational): stage 0 valid & is_load & rd != 0 & rd matches any used source of a valid decode instruction. Lasts exactly 1 cycle per load.
- Flag reg: updated with alu_flag at clk when alu_flag_we. Branches evaluate against the registered value.
- Condition codes:
  - 000 EQ (Z)
  - 001 NE (!Z)
  - 010 GT (!Z & !N)
  - 011 LT (N)
  - 100 GE (Z | !N)
  - 101 LE (Z | N)
  - 110 OV (V)
  - 111 always
- branch_taken (combinational): id_valid & !stall & ((opcode 0xC & cond true) | opcode 0xD | opcode 0xE).
- flush: registered copy of branch_taken, 1-cycle pulse.
- EXEC FSM states IDLE, EXEC_WAIT, EXEC_RUN:
  - IDLE → EXEC_WAIT on valid, unstalled opcode 0xF.
  - EXEC_WAIT → EXEC_RUN after 1 cycle; target fetched.
  - EXEC_RUN → IDLE after 1 cycle; exec_active = 1 only in EXEC_RUN.
  - A stall holds the current state.
  - A nested EXEC in EXEC_RUN is treated as a NOP: no state change, no scoreboard write.
- Simultaneous events:
  - Stall has priority over branch_taken; the branch is re-evaluated next cycle.
  - A flush during EXEC_WAIT returns the FSM to IDLE.
- A mid-operation rst aborts everything; all state returns to reset values at that edge.

Optional Feature:
HAZARD_STATS_EN
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0]. Each increments on its event, saturates at 0xFFFF, and clears on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ADD..OP_EXEC);
  - condition encodings (COND_EQ..COND_TRUE);
  - flag bit indices (FLAG_N=2, FLAG_V=1, FLAG_Z=0);
  - FSM state enum;
  - the scoreboard entry struct.
- One sub-module: hazard_cond_eval, purely combinational {cond, flags} → taken.

Test Plan:
- ADD r3 ← r1,r2 then SUB r4 ← r3,r5 back-to-back, DEPTH=2 → fwd_sel_rs = 1, stall = 0.
- ADD r3 writes, one unrelated instr, then OR r6 ← r7,r3 → fwd_sel_rt = 2. Same case with DEPTH=1 → fwd_sel_rt = 0.
- LW r2 then ADD r4 ← r2,r1 → stall = 1 for exactly one cycle, then fwd_sel_rs = 2. Destination r0 anywhere → never forwards or stalls.
- SUB setting flags Z=1, then B cond=000 → branch_taken = 1 and flush = 1 next cycle. cond=001 → both 0.
- EXEC r5 → exec_active low, low, high, low. rst asserted in EXEC_WAIT → IDLE next cycle, scoreboard empty.
- With HAZARD_STATS_EN: 3 load-use stalls and 2 taken branches → stall_cnt = 3, flush_cnt = 2.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard / forwarding controller:
//   - 4-bit opcode constants (OP_ADD .. OP_EXEC)
//   - 3-bit branch condition encodings (COND_EQ .. COND_TRUE)
//   - bit positions of N, V, Z inside the {N,V,Z} flag vector
//   - EXEC sequencing FSM state enum
//   - scoreboard entry struct
//   - opcode classification helpers (register write / operand usage)
// No ports (package).
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOT  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_LI   = 4'hA;
   localparam logic [3:0] OP_LUI  = 4'hB;
   localparam logic [3:0] OP_BR   = 4'hC;
   localparam logic [3:0] OP_JAL  = 4'hD;
   localparam logic [3:0] OP_JR   = 4'hE;
   localparam logic [3:0] OP_EXEC = 4'hF;

   localparam logic [2:0] COND_EQ   = 3'b000;
   localparam logic [2:0] COND_NE   = 3'b001;
   localparam logic [2:0] COND_GT   = 3'b010;
   localparam logic [2:0] COND_LT   = 3'b011;
   localparam logic [2:0] COND_GE   = 3'b100;
   localparam logic [2:0] COND_LE   = 3'b101;
   localparam logic [2:0] COND_OV   = 3'b110;
   localparam logic [2:0] COND_TRUE = 3'b111;

   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   // Register addresses are zero-extended to this width inside the
   // scoreboard so one struct serves every RSIZE up to 8.
   localparam int SB_RD_MAX = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      EXEC_WAIT = 2'd1,
      EXEC_RUN  = 2'd2
   } execState_t;

   typedef struct packed {
      logic                 valid;
      logic [SB_RD_MAX-1:0] rd;
      logic                 isLoad;
   } sbEntry_t;

   // Opcodes whose result lands in the register file (JAL writes the link).
   function automatic logic opWritesReg(input logic [3:0] op);
      logic result;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
         OP_LW, OP_LI, OP_LUI, OP_JAL: result = 1'b1;
         default:                      result = 1'b0;
      endcase
      return result;
   endfunction

   // Opcodes that read the rs operand (ALU group, loads and stores).
   function automatic logic opUsesRs(input logic [3:0] op);
      logic result;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
         OP_LW, OP_SW: result = 1'b1;
         default:      result = 1'b0;
      endcase
      return result;
   endfunction

   // Opcodes that read the rt operand (two-register ALU ops only).
   function automatic logic opUsesRt(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

   // Opcodes that read rd as an operand; this operand uses the rt mux.
   function automatic logic opReadsRd(input logic [3:0] op);
      return (op == OP_SW) || (op == OP_JR) || (op == OP_EXEC);
   endfunction

endpackage

// File: rtl/hazard_cond_eval.sv
// ---------------------------------------------------------------------------
// hazard_cond_eval
// Purely combinational branch condition evaluator.
// Ports:
//   i_cond  [2:0]  branch condition field
//   i_flags [2:0]  registered {N,V,Z} flags
//   o_taken        condition holds
// ---------------------------------------------------------------------------
module hazard_cond_eval
   import hazard_ctrl_pkg::*;
(
   input  logic [2:0] i_cond,
   input  logic [2:0] i_flags,
   output logic       o_taken
);

   logic w_n;
   logic w_v;
   logic w_z;

   assign w_n = i_flags[FLAG_N];
   assign w_v = i_flags[FLAG_V];
   assign w_z = i_flags[FLAG_Z];

   // Decode the condition field against the flag bits.
   always_comb begin
      o_taken = 1'b0;
      case (i_cond)
         COND_EQ:   o_taken = w_z;
         COND_NE:   o_taken = ~w_z;
         COND_GT:   o_taken = ~w_z & ~w_n;
         COND_LT:   o_taken = w_n;
         COND_GE:   o_taken = w_z | ~w_n;
         COND_LE:   o_taken = w_z | w_n;
         COND_OV:   o_taken = w_v;
         COND_TRUE: o_taken = 1'b1;
         default:   o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard and forwarding controller beside the decode stage.
// Tracks the destinations of the last DEPTH issued instructions in a
// shift-register scoreboard, derives operand forwarding selects, a one-cycle
// load-use stall, branch redirect / fetch flush, and sequences EXEC.
//
// Parameters: RSIZE (reg address width, <= 8), DEPTH (1..4), SELW (2**SELW > DEPTH)
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   id_valid              decode slot holds a real instruction
//   id_opcode/id_cond     decoded opcode and branch condition
//   id_rd/id_rs/id_rt     register fields
//   alu_flag, alu_flag_we {N,V,Z} from execute and its write enable
//   fwd_sel_rs/rt         0 = register file, k = scoreboard stage k-1
//   stall, flush          pipeline hold / kill fetch (flush is registered)
//   branch_taken          redirect PC
//   exec_active           EXEC target occupies decode
// Optional build macro HAZARD_STATS_EN adds stall_cnt / flush_cnt outputs
// (16-bit saturating event counters).
// ---------------------------------------------------------------------------
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int RSIZE = 4,
   parameter int DEPTH = 2,
   parameter int SELW  = 3
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [3:0]       id_opcode,
   input  logic [2:0]       id_cond,
   input  logic [RSIZE-1:0] id_rd,
   input  logic [RSIZE-1:0] id_rs,
   input  logic [RSIZE-1:0] id_rt,
   input  logic [2:0]       alu_flag,
   input  logic             alu_flag_we,
   output logic [SELW-1:0]  fwd_sel_rs,
   output logic [SELW-1:0]  fwd_sel_rt,
   output logic             stall,
   output logic             flush,
   output logic             branch_taken,
   output logic             exec_active
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]      stall_cnt,
   output logic [15:0]      flush_cnt
`endif
);

   sbEntry_t             r_sb [DEPTH];
   sbEntry_t             w_sbIn;
   logic [2:0]           r_flags;
   logic                 r_flush;
   execState_t           r_state;
   execState_t           w_stateNext;

   logic                 w_writes;
   logic                 w_usesRs;
   logic                 w_rtUsed;
   logic                 w_condTrue;
   logic                 w_loadHead;
   logic [SB_RD_MAX-1:0] w_rsExt;
   logic [SB_RD_MAX-1:0] w_rdExt;
   logic [SB_RD_MAX-1:0] w_rtSrcExt;

   // Classify the decode instruction. The rt mux carries either rt or the
   // rd-as-source operand; no opcode needs both.
   assign w_writes   = opWritesReg(id_opcode);
   assign w_usesRs   = opUsesRs(id_opcode);
   assign w_rtUsed   = opUsesRt(id_opcode) | opReadsRd(id_opcode);
   assign w_rsExt    = SB_RD_MAX'(id_rs);
   assign w_rdExt    = SB_RD_MAX'(id_rd);
   assign w_rtSrcExt = opUsesRt(id_opcode) ? SB_RD_MAX'(id_rt) : w_rdExt;

   // Forwarding selects: scanning oldest to youngest lets the youngest
   // matching stage overwrite older ones. Unused operands and r0 stay on
   // the register file so the selects are quiet when nothing is needed.
   always_comb begin
      fwd_sel_rs = '0;
      fwd_sel_rt = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (r_sb[k].valid && (r_sb[k].rd == w_rsExt)) begin
            fwd_sel_rs = SELW'(k + 1);
         end
         if (r_sb[k].valid && (r_sb[k].rd == w_rtSrcExt)) begin
            fwd_sel_rt = SELW'(k + 1);
         end
      end
      if (!id_valid || !w_usesRs || (w_rsExt == '0)) begin
         fwd_sel_rs = '0;
      end
      if (!id_valid || !w_rtUsed || (w_rtSrcExt == '0)) begin
         fwd_sel_rt = '0;
      end
   end

   // Load-use: a load one stage ahead cannot forward yet. The stall drops a
   // bubble into stage 0, so the load moves to stage 1 and the stall ends.
   assign w_loadHead = r_sb[0].valid & r_sb[0].isLoad & (r_sb[0].rd != '0);
   assign stall = id_valid & w_loadHead &
                  ((w_usesRs & (r_sb[0].rd == w_rsExt)) |
                   (w_rtUsed & (r_sb[0].rd == w_rtSrcExt)));

   hazard_cond_eval u_condEval (
      .i_cond  (id_cond),
      .i_flags (r_flags),
      .o_taken (w_condTrue)
   );

   // A stalled branch is held back and re-evaluated once the stall clears.
   assign branch_taken = id_valid & ~stall &
                         (((id_opcode == OP_BR) & w_condTrue) |
                          (id_opcode == OP_JAL) | (id_opcode == OP_JR));
   assign flush = r_flush;

   // Entry entering stage 0: a bubble whenever decode is stalled or does
   // not write a register.
   always_comb begin
      w_sbIn        = '0;
      w_sbIn.valid  = id_valid & w_writes & ~stall;
      if (w_sbIn.valid) begin
         w_sbIn.rd     = w_rdExt;
         w_sbIn.isLoad = (id_opcode == OP_LW);
      end
   end

   // Scoreboard shift register: advances every cycle, stall or not, so
   // in-flight results keep draining towards writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_sb[k] <= '0;
         end
      end else begin
         r_sb[0] <= w_sbIn;
         for (int k = 1; k < DEPTH; k++) begin
            r_sb[k] <= r_sb[k-1];
         end
      end
   end

   // Flag register, flush pulse and FSM state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flags <= 3'b000;
         r_flush <= 1'b0;
         r_state <= IDLE;
      end else begin
         if (alu_flag_we) begin
            r_flags <= alu_flag;
         end
         r_flush <= branch_taken;
         r_state <= w_stateNext;
      end
   end

   // EXEC sequencing: EXEC_WAIT covers the target fetch, EXEC_RUN is the
   // cycle the target sits in decode. A stall freezes the sequence; a flush
   // while waiting abandons it. An EXEC seen in EXEC_RUN is ignored.
   always_comb begin
      w_stateNext = r_state;
      exec_active = 1'b0;
      case (r_state)
         IDLE: begin
            if (id_valid && !stall && (id_opcode == OP_EXEC)) begin
               w_stateNext = EXEC_WAIT;
            end
         end
         EXEC_WAIT: begin
            if (r_flush) begin
               w_stateNext = IDLE;
            end else if (!stall) begin
               w_stateNext = EXEC_RUN;
            end
         end
         EXEC_RUN: begin
            exec_active = 1'b1;
            if (!stall) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] r_stallCnt;
   logic [15:0] r_flushCnt;

   // Saturating event counters for stall cycles and flush pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stallCnt <= 16'd0;
         r_flushCnt <= 16'd0;
      end else begin
         if (stall && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
         end
         if (r_flush && (r_flushCnt != 16'hFFFF)) begin
            r_flushCnt <= r_flushCnt + 16'd1;
         end
      end
   end

   assign stall_cnt = r_stallCnt;
   assign flush_cnt = r_flushCnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Drives one instruction stream into two hazard_ctrl instances (DEPTH=2 and
// DEPTH=1) and checks both against an instruction-history model every cycle,
// plus hand-computed expectations at key points.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [3:0] id_opcode;
   logic [2:0] id_cond;
   logic [3:0] id_rd;
   logic [3:0] id_rs;
   logic [3:0] id_rt;
   logic [2:0] alu_flag;
   logic       alu_flag_we;

   logic [2:0] selRsA, selRtA, selRsB, selRtB;
   logic       stallA, flushA, branchA, execA;
   logic       stallB, flushB, branchB, execB;
`ifdef HAZARD_STATS_EN
   logic [15:0] stallCntA, flushCntA, stallCntB, flushCntB;
`endif

   int nChecks = 0;
   int nPass   = 0;
   bit compareEn = 1'b0;

   // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   hazard_ctrl #(.RSIZE(4), .DEPTH(2), .SELW(3)) dutA (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_cond(id_cond), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
      .alu_flag(alu_flag), .alu_flag_we(alu_flag_we),
      .fwd_sel_rs(selRsA), .fwd_sel_rt(selRtA), .stall(stallA),
      .flush(flushA), .branch_taken(branchA), .exec_active(execA)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stallCntA), .flush_cnt(flushCntA)
`endif
   );

   hazard_ctrl #(.RSIZE(4), .DEPTH(1), .SELW(3)) dutB (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_cond(id_cond), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
      .alu_flag(alu_flag), .alu_flag_we(alu_flag_we),
      .fwd_sel_rs(selRsB), .fwd_sel_rt(selRtB), .stall(stallB),
      .flush(flushB), .branch_taken(branchB), .exec_active(execB)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stallCntB), .flush_cnt(flushCntB)
`endif
   );

   // ---------------- behavioural model ----------------
   // History of what entered the pipeline in the last four cycles,
   // index 0 = most recent issue slot.
   logic       mValid [4];
   logic [3:0] mRd    [4];
   logic       mLoad  [4];
   logic [2:0] mFlags;
   logic       mFlush;
   int         mPhase;   // 0 idle, 1 waiting for target, 2 target in decode

   function automatic bit isWriter(input logic [3:0] op);
      return (op <= 4'd8) || (op == 4'd10) || (op == 4'd11) || (op == 4'd13);
   endfunction

   function automatic bit readsRs(input logic [3:0] op);
      return op <= 4'd9;
   endfunction

   function automatic bit readsRt(input logic [3:0] op);
      return op <= 4'd3;
   endfunction

   function automatic bit readsRdOp(input logic [3:0] op);
      return (op == 4'd9) || (op == 4'd14) || (op == 4'd15);
   endfunction

   function automatic logic [3:0] secondSrc();
      return readsRt(id_opcode) ? id_rt : id_rd;
   endfunction

   function automatic bit secondUsed();
      return readsRt(id_opcode) || readsRdOp(id_opcode);
   endfunction

   // Youngest earlier writer of src among the last 'depth' issue slots.
   function automatic int expSel(input int depth, input logic [3:0] src, input bit used);
      if (!id_valid || !used || (src == 4'd0)) return 0;
      for (int k = 0; k < depth; k++) begin
         if (mValid[k] && (mRd[k] == src)) return k + 1;
      end
      return 0;
   endfunction

   function automatic bit expStall();
      if (!id_valid || !mValid[0] || !mLoad[0] || (mRd[0] == 4'd0)) return 1'b0;
      return (readsRs(id_opcode) && (id_rs == mRd[0])) ||
             (secondUsed() && (secondSrc() == mRd[0]));
   endfunction

   function automatic bit condHolds(input logic [2:0] c, input logic [2:0] f);
      bit n, v, z;
      n = f[2];
      v = f[1];
      z = f[0];
      case (c)
         3'd0:    return z;
         3'd1:    return !z;
         3'd2:    return !z && !n;
         3'd3:    return n;
         3'd4:    return z || !n;
         3'd5:    return z || n;
         3'd6:    return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic bit expBranch();
      if (!id_valid || expStall()) return 1'b0;
      return ((id_opcode == 4'hC) && condHolds(id_cond, mFlags)) ||
             (id_opcode == 4'hD) || (id_opcode == 4'hE);
   endfunction

   // Advance the model at each rising edge.
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            mValid[k] <= 1'b0;
            mRd[k]    <= 4'd0;
            mLoad[k]  <= 1'b0;
         end
         mFlags <= 3'b000;
         mFlush <= 1'b0;
         mPhase <= 0;
      end else begin
         mValid[0] <= id_valid && isWriter(id_opcode) && !expStall();
         mRd[0]    <= id_rd;
         mLoad[0]  <= (id_opcode == 4'h8);
         for (int k = 1; k < 4; k++) begin
            mValid[k] <= mValid[k-1];
            mRd[k]    <= mRd[k-1];
            mLoad[k]  <= mLoad[k-1];
         end
         if (alu_flag_we) mFlags <= alu_flag;
         mFlush <= expBranch();
         if (mPhase == 0) begin
            if (id_valid && !expStall() && (id_opcode == 4'hF)) mPhase <= 1;
         end else if (mPhase == 1) begin
            if (mFlush) mPhase <= 0;
            else if (!expStall()) mPhase <= 2;
         end else begin
            if (!expStall()) mPhase <= 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
      end else begin
         nPass++;
      end
   endtask

   // Per-cycle comparison on the falling edge, inputs and outputs stable.
   always @(negedge clk) begin
      if (compareEn) begin
         checkOutput("sel_rs_d2", 32'(selRsA), 32'(expSel(2, id_rs, readsRs(id_opcode))));
         checkOutput("sel_rt_d2", 32'(selRtA), 32'(expSel(2, secondSrc(), secondUsed())));
         checkOutput("sel_rs_d1", 32'(selRsB), 32'(expSel(1, id_rs, readsRs(id_opcode))));
         checkOutput("sel_rt_d1", 32'(selRtB), 32'(expSel(1, secondSrc(), secondUsed())));
         checkOutput("stall_d2",  32'(stallA),  32'(expStall()));
         checkOutput("stall_d1",  32'(stallB),  32'(expStall()));
         checkOutput("branch_d2", 32'(branchA), 32'(expBranch()));
         checkOutput("branch_d1", 32'(branchB), 32'(expBranch()));
         checkOutput("flush_d2",  32'(flushA),  32'(mFlush));
         checkOutput("flush_d1",  32'(flushB),  32'(mFlush));
         checkOutput("exec_d2",   32'(execA),   32'(mPhase == 2));
         checkOutput("exec_d1",   32'(execB),   32'(mPhase == 2));
      end
   end

   // ---------------- stimulus ----------------
   // Present one instruction in decode for one cycle (driven 1 after the edge).
   task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [2:0] cond,
                                input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                                input logic we, input logic [2:0] flg);
      @(posedge clk);
      #1;
      id_valid    = v;
      id_opcode   = op;
      id_cond     = cond;
      id_rd       = rd;
      id_rs       = rs;
      id_rt       = rt;
      alu_flag_we = we;
      alu_flag    = flg;
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 4'h0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 3'b000);
   endtask

   initial begin
      rst = 1'b1;
      id_valid = 1'b0; id_opcode = 4'h0; id_cond = 3'd0;
      id_rd = 4'd0; id_rs = 4'd0; id_rt = 4'd0;
      alu_flag = 3'b000; alu_flag_we = 1'b0;
      @(posedge clk);
      #1;
      compareEn = 1'b1;
      checkOutput("reset_sel_rs", 32'(selRsA), 32'd0);
      checkOutput("reset_stall",  32'(stallA), 32'd0);
      checkOutput("reset_flush",  32'(flushA), 32'd0);
      checkOutput("reset_exec",   32'(execA),  32'd0);
      checkOutput("reset_branch", 32'(branchA), 32'd0);
      idleCycle();
      rst = 1'b0;

      // Back-to-back dependency: ADD r3 <- r1,r2 ; SUB r4 <- r3,r5
      applyStimulus(1, 4'h0, 0, 4'd3, 4'd1, 4'd2, 0, 0);
      checkOutput("add_no_fwd", 32'(selRsA), 32'd0);
      applyStimulus(1, 4'h1, 0, 4'd4, 4'd3, 4'd5, 0, 0);
      checkOutput("sub_fwd_rs", 32'(selRsA), 32'd1);
      checkOutput("sub_no_stall", 32'(stallA), 32'd0);

      // Distance-two dependency: ADD r3 ; ADD r8 <- r9,r10 ; OR r6 <- r7,r3
      applyStimulus(1, 4'h0, 0, 4'd3, 4'd1, 4'd2, 0, 0);
      applyStimulus(1, 4'h0, 0, 4'd8, 4'd9, 4'd10, 0, 0);
      applyStimulus(1, 4'h3, 0, 4'd6, 4'd7, 4'd3, 0, 0);
      checkOutput("or_fwd_rt_d2", 32'(selRtA), 32'd2);
      checkOutput("or_fwd_rt_d1", 32'(selRtB), 32'd0);

      // Load-use: LW r2 ; ADD r4 <- r2,r1 (stalls once, then re-presented)
      applyStimulus(1, 4'h8, 0, 4'd2, 4'd1, 4'd0, 0, 0);
      applyStimulus(1, 4'h0, 0, 4'd4, 4'd2, 4'd1, 0, 0);
      checkOutput("lu_stall", 32'(stallA), 32'd1);
      applyStimulus(1, 4'h0, 0, 4'd4, 4'd2, 4'd1, 0, 0);
      checkOutput("lu_stall_end", 32'(stallA), 32'd0);
      checkOutput("lu_fwd_rs", 32'(selRsA), 32'd2);

      // Destination r0 never forwards or stalls
      applyStimulus(1, 4'h8, 0, 4'd0, 4'd1, 4'd0, 0, 0);
      applyStimulus(1, 4'h0, 0, 4'd5, 4'd0, 4'd0, 0, 0);
      checkOutput("r0_no_stall", 32'(stallA), 32'd0);
      checkOutput("r0_no_fwd",   32'(selRsA), 32'd0);

      // Flags: SUB sets Z, then B EQ taken, B NE not taken
      applyStimulus(1, 4'h1, 0, 4'd7, 4'd1, 4'd1, 1, 3'b001);
      applyStimulus(1, 4'hC, 3'b000, 4'd0, 4'd0, 4'd0, 0, 0);
      checkOutput("beq_taken", 32'(branchA), 32'd1);
      applyStimulus(1, 4'hC, 3'b001, 4'd0, 4'd0, 4'd0, 0, 0);
      checkOutput("beq_flush", 32'(flushA), 32'd1);
      checkOutput("bne_not_taken", 32'(branchA), 32'd0);
      idleCycle();
      checkOutput("bne_no_flush", 32'(flushA), 32'd0);

      // EXEC r5 : exec_active low, low, high, low
      applyStimulus(1, 4'hF, 0, 4'd5, 4'd0, 4'd0, 0, 0);
      checkOutput("exec_c0", 32'(execA), 32'd0);
      idleCycle();
      checkOutput("exec_c1", 32'(execA), 32'd0);
      idleCycle();
      checkOutput("exec_c2", 32'(execA), 32'd1);
      idleCycle();
      checkOutput("exec_c3", 32'(execA), 32'd0);

      // Reset while in EXEC_WAIT clears the FSM and the scoreboard
      applyStimulus(1, 4'h0, 0, 4'd1, 4'd2, 4'd3, 0, 0);
      applyStimulus(1, 4'hF, 0, 4'd5, 4'd0, 4'd0, 0, 0);
      applyStimulus(1, 4'h0, 0, 4'd6, 4'd1, 4'd1, 0, 0);
      rst = 1'b1;
      checkOutput("rst_wait_exec", 32'(execA), 32'd0);
      applyStimulus(1, 4'h0, 0, 4'd7, 4'd6, 4'd6, 0, 0);
      rst = 1'b0;
      checkOutput("rst_sb_empty_rs", 32'(selRsA), 32'd0);
      checkOutput("rst_sb_empty_rt", 32'(selRtA), 32'd0);
      checkOutput("rst_exec_idle", 32'(execA), 32'd0);

      // Nested EXEC while the target runs is ignored
      applyStimulus(1, 4'hF, 0, 4'd5, 4'd0, 4'd0, 0, 0);
      idleCycle();
      applyStimulus(1, 4'hF, 0, 4'd5, 4'd0, 4'd0, 0, 0);
      checkOutput("nest_run", 32'(execA), 32'd1);
      idleCycle();
      idleCycle();
      checkOutput("nest_ignored", 32'(execA), 32'd0);

      // JAL r15 then JR r15 (rd operand forwarded on the rt select)
      applyStimulus(1, 4'hD, 0, 4'd15, 4'd0, 4'd0, 0, 0);
      checkOutput("jal_taken", 32'(branchA), 32'd1);
      applyStimulus(1, 4'hE, 0, 4'd15, 4'd0, 4'd0, 0, 0);
      checkOutput("jr_taken", 32'(branchA), 32'd1);
      checkOutput("jr_fwd_rt", 32'(selRtA), 32'd1);
      idleCycle();

      // Stall beats branch: LW r9 ; JR r9 (held) ; JR r9
      applyStimulus(1, 4'h8, 0, 4'd9, 4'd1, 4'd0, 0, 0);
      applyStimulus(1, 4'hE, 0, 4'd9, 4'd0, 4'd0, 0, 0);
      checkOutput("jr_stalled", 32'(stallA), 32'd1);
      checkOutput("jr_held", 32'(branchA), 32'd0);
      applyStimulus(1, 4'hE, 0, 4'd9, 4'd0, 4'd0, 0, 0);
      checkOutput("jr_retry", 32'(branchA), 32'd1);
      checkOutput("jr_retry_fwd", 32'(selRtA), 32'd2);

      // N=1: LT taken, GT not, GE not, LE taken, OV not
      applyStimulus(0, 4'h0, 0, 4'd0, 4'd0, 4'd0, 1, 3'b100);
      applyStimulus(1, 4'hC, 3'b011, 4'd0, 4'd0, 4'd0, 0, 0);
      checkOutput("blt_taken", 32'(branchA), 32'd1);
      applyStimulus(1, 4'hC, 3'b010, 4'd0, 4'd0, 4'd0, 0, 0);
      checkOutput("bgt_not", 32'(branchA), 32'd0);
      applyStimulus(1, 4'hC, 3'b100, 4'd0, 4'd0, 4'd0, 0, 0);
      applyStimulus(1, 4'hC, 3'b101, 4'd0, 4'd0, 4'd0, 0, 0);
      checkOutput("ble_taken", 32'(branchA), 32'd1);
      applyStimulus(1, 4'hC, 3'b110, 4'd0, 4'd0, 4'd0, 0, 0);

      // Event run from a fresh reset: three load-use stalls, two taken branches
      applyStimulus(0, 4'h0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
      rst = 1'b1;
      idleCycle();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 4'h8, 0, 4'd2, 4'd1, 4'd0, 0, 0);
         applyStimulus(1, 4'h0, 0, 4'd4, 4'd2, 4'd1, 0, 0);
         applyStimulus(1, 4'h0, 0, 4'd4, 4'd2, 4'd1, 0, 0);
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 4'hC, 3'b111, 4'd0, 4'd0, 4'd0, 0, 0);
         idleCycle();
      end
      idleCycle();
`ifdef HAZARD_STATS_EN
      checkOutput("stall_cnt", 32'(stallCntA), 32'd3);
      checkOutput("flush_cnt", 32'(flushCntA), 32'd2);
`endif

      @(posedge clk);
      #1;
      compareEn = 1'b0;
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
